// File: rtl/pool1_reader.sv
// pool1_reader: streams an f2 feature map through 2x2 windows and emits the
// per-lane signed maximum of each window (six 16-bit lanes in parallel).
module pool1_reader #(
    parameter int unsigned MAP_W = 28,
    parameter int unsigned AW    = 10,
    parameter int unsigned PW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          f2_rd_en,
    output logic [AW-1:0] f2_raddr,
    input  logic [95:0]   f2_rdata,
    output logic          p_valid,
    output logic [95:0]   p_data,
    output logic [PW-1:0] p_addr,
    output logic          done
);

    localparam int unsigned HALF  = MAP_W / 2;
    localparam int unsigned CW    = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int unsigned LANES = 6;
    localparam int unsigned LW    = 16;

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t          r_state;
    state_t          w_next;

    // read-side window position of the read currently on f2_raddr
    logic [CW-1:0]   r_pr;
    logic [CW-1:0]   r_pc;
    logic [1:0]      r_el;
    logic [PW-1:0]   r_win;

    // one-cycle-delayed tags aligned with returning f2_rdata
    logic            r_cap;
    logic [1:0]      r_cap_el;
    logic [PW-1:0]   r_cap_win;
    logic            r_cap_last;

    logic [95:0]     r_acc;
    logic            r_busy;
    logic            r_rd_en;
    logic [AW-1:0]   r_raddr;
    logic            r_pvalid;
    logic [95:0]     r_pdata;
    logic [PW-1:0]   r_paddr;
    logic            r_done;

    logic            w_last_rd;
    logic [CW-1:0]   w_pr_n;
    logic [CW-1:0]   w_pc_n;
    logic [1:0]      w_el_n;
    int unsigned     w_addr_n;
    logic [95:0]     w_max;

    assign busy     = r_busy;
    assign f2_rd_en = r_rd_en;
    assign f2_raddr = r_raddr;
    assign p_valid  = r_pvalid;
    assign p_data   = r_pdata;
    assign p_addr   = r_paddr;
    assign done     = r_done;

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start)     w_next = READ;
            READ:    if (w_last_rd) w_next = DRAIN;
            DRAIN:   if (r_done)    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // next window position and its row-major f2 address
    always_comb begin
        w_last_rd = (r_state == READ) && (r_el == 2'd3) &&
                    (r_pc == CW'(HALF - 1)) && (r_pr == CW'(HALF - 1));
        w_el_n = r_el + 2'd1;
        w_pc_n = r_pc;
        w_pr_n = r_pr;
        if (r_el == 2'd3) begin
            if (r_pc == CW'(HALF - 1)) begin
                w_pc_n = '0;
                w_pr_n = r_pr + CW'(1);
            end else begin
                w_pc_n = r_pc + CW'(1);
            end
        end
        w_addr_n = 2 * 32'(w_pr_n) * MAP_W + 2 * 32'(w_pc_n) +
                   (w_el_n[1] ? MAP_W : 0) + 32'(w_el_n[0]);
    end

    // per-lane signed maximum of accumulator and returning pixel
    always_comb begin
        w_max = '0;
        for (int l = 0; l < int'(LANES); l++) begin
            if ($signed(r_acc[l*LW +: LW]) > $signed(f2_rdata[l*LW +: LW]))
                w_max[l*LW +: LW] = r_acc[l*LW +: LW];
            else
                w_max[l*LW +: LW] = f2_rdata[l*LW +: LW];
        end
    end

    // read issue, capture pipeline, accumulation and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pr       <= '0;
            r_pc       <= '0;
            r_el       <= '0;
            r_win      <= '0;
            r_cap      <= 1'b0;
            r_cap_el   <= '0;
            r_cap_win  <= '0;
            r_cap_last <= 1'b0;
            r_acc      <= '0;
            r_busy     <= 1'b0;
            r_rd_en    <= 1'b0;
            r_raddr    <= '0;
            r_pvalid   <= 1'b0;
            r_pdata    <= '0;
            r_paddr    <= '0;
            r_done     <= 1'b0;
        end else begin
            r_pvalid   <= 1'b0;
            r_done     <= 1'b0;
            r_cap      <= r_rd_en;
            r_cap_el   <= r_el;
            r_cap_win  <= r_win;
            r_cap_last <= w_last_rd;

            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_busy  <= 1'b1;
                        r_rd_en <= 1'b1;
                        r_raddr <= '0;
                        r_pr    <= '0;
                        r_pc    <= '0;
                        r_el    <= '0;
                        r_win   <= '0;
                    end
                end
                READ: begin
                    if (w_last_rd) begin
                        r_rd_en <= 1'b0;
                        r_raddr <= '0;
                        r_pr    <= '0;
                        r_pc    <= '0;
                        r_el    <= '0;
                        r_win   <= '0;
                    end else begin
                        r_pr    <= w_pr_n;
                        r_pc    <= w_pc_n;
                        r_el    <= w_el_n;
                        r_raddr <= AW'(w_addr_n);
                        if (r_el == 2'd3) r_win <= r_win + PW'(1);
                    end
                end
                DRAIN: begin
                    if (r_done) r_busy <= 1'b0;
                end
                default: ;
            endcase

            if (r_cap) begin
                if (r_cap_el == 2'd0) r_acc <= f2_rdata;
                else                  r_acc <= w_max;
                if (r_cap_el == 2'd3) begin
                    r_pvalid <= 1'b1;
                    r_pdata  <= w_max;
                    r_paddr  <= r_cap_win;
                    r_done   <= r_cap_last;
                end
            end
        end
    end

endmodule

// File: tb/tb_pool1_reader.sv
// Directed bench for pool1_reader with a one-cycle-latency f2 memory model.
`timescale 1ns/1ps
module tb_pool1_reader;

    localparam int MAP_W = 28;
    localparam int AW    = 10;
    localparam int PW    = 8;
    localparam int HALF  = 14;
    localparam int NWIN  = 196;
    localparam int NRD   = 784;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy;
    logic          f2_rd_en;
    logic [AW-1:0] f2_raddr;
    logic [95:0]   f2_rdata;
    logic          p_valid;
    logic [95:0]   p_data;
    logic [PW-1:0] p_addr;
    logic          done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit sig_mode = 1'b0;

    pool1_reader #(.MAP_W(MAP_W), .AW(AW), .PW(PW)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy),
        .f2_rd_en(f2_rd_en), .f2_raddr(f2_raddr), .f2_rdata(f2_rdata),
        .p_valid(p_valid), .p_data(p_data), .p_addr(p_addr), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [95:0] mem_word(input int a);
        logic [95:0] w;
        logic signed [15:0] v;
        w = '0;
        for (int i = 0; i < 6; i++) begin
            v = 16'(a + 256 * i);
            if (sig_mode) begin
                if (a == 0)  v = -16'sd5;
                if (a == 1)  v = -16'sd1;
                if (a == 28) v = -16'sd300;
                if (a == 29) v = -16'sd2;
            end
            w[16*i +: 16] = v;
        end
        return w;
    endfunction

    function automatic logic [95:0] exp_word(input int w, input bit sm);
        logic [95:0] r;
        int base;
        base = 2 * (w / HALF) * MAP_W + 2 * (w % HALF);
        r = '0;
        for (int i = 0; i < 6; i++) begin
            if (sm && w == 0) r[16*i +: 16] = 16'hFFFF;
            else              r[16*i +: 16] = 16'(base + MAP_W + 1 + 256 * i);
        end
        return r;
    endfunction

    // f2 memory: data valid the cycle after the read strobe
    initial f2_rdata = '0;
    always @(posedge clk) if (f2_rd_en) f2_rdata <= mem_word(int'(f2_raddr));

    // observation records
    int          rd_addr_q[$];
    int          rd_cyc_q[$];
    logic [95:0] pv_data_q[$];
    int          pv_addr_q[$];
    int          pv_cyc_q[$];
    int          done_cyc_q[$];
    int          done_paddr_q[$];
    bit          done_pv_q[$];
    int          max_addr;
    int          hold_bad;
    logic [95:0] prev_d = '0;
    logic [PW-1:0] prev_a = '0;

    always @(negedge clk) begin
        if (!rst) begin
            if (f2_rd_en) begin
                rd_addr_q.push_back(int'(f2_raddr));
                rd_cyc_q.push_back(cyc);
                if (int'(f2_raddr) > max_addr) max_addr = int'(f2_raddr);
            end
            if (p_valid) begin
                pv_data_q.push_back(p_data);
                pv_addr_q.push_back(int'(p_addr));
                pv_cyc_q.push_back(cyc);
            end else if (p_data !== prev_d || p_addr !== prev_a) begin
                hold_bad++;
            end
            if (done) begin
                done_cyc_q.push_back(cyc);
                done_paddr_q.push_back(int'(p_addr));
                done_pv_q.push_back(p_valid);
            end
        end
        prev_d = p_data;
        prev_a = p_addr;
    end

    task automatic clear_rec();
        rd_addr_q.delete(); rd_cyc_q.delete();
        pv_data_q.delete(); pv_addr_q.delete(); pv_cyc_q.delete();
        done_cyc_q.delete(); done_paddr_q.delete(); done_pv_q.delete();
        max_addr = 0;
        hold_bad = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_done_timeout: done not seen within 3000 cycles", tag);
        end
    endtask

    // full-run checks for run index r in the current records
    task automatic check_run(input string tag, input int r, input bit sm);
        int pb, rb, f;
        int first8[8];
        first8 = '{0, 1, 28, 29, 2, 3, 30, 31};
        pb = r * NWIN;
        rb = r * NRD;
        checks++;
        if (pv_data_q.size() < pb + NWIN) begin
            errors++;
            $display("FAIL %s_pv_count: got %0d required %0d", tag, pv_data_q.size() - pb, NWIN);
            return;
        end
        checks++;
        if (rd_addr_q.size() < rb + NRD) begin
            errors++;
            $display("FAIL %s_rd_count: got %0d required %0d", tag, rd_addr_q.size() - rb, NRD);
            return;
        end
        for (int w = 0; w < NWIN; w++) begin
            checks++;
            if (pv_addr_q[pb+w] !== w || pv_data_q[pb+w] !== exp_word(w, sm)) begin
                errors++;
                $display("FAIL %s_window%0d: addr %0d data %h required addr %0d data %h",
                         tag, w, pv_addr_q[pb+w], pv_data_q[pb+w], w, exp_word(w, sm));
            end
            if (w > 0) begin
                checks++;
                if (pv_cyc_q[pb+w] - pv_cyc_q[pb+w-1] !== 4) begin
                    errors++;
                    $display("FAIL %s_pv_spacing%0d: got %0d required 4", tag, w,
                             pv_cyc_q[pb+w] - pv_cyc_q[pb+w-1]);
                end
            end
        end
        f = rd_cyc_q[rb];
        checks++;
        if (pv_cyc_q[pb] - f !== 5) begin
            errors++;
            $display("FAIL %s_first_pv_latency: got %0d required 5", tag, pv_cyc_q[pb] - f);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (rd_addr_q[rb+i] !== first8[i]) begin
                errors++;
                $display("FAIL %s_raddr%0d: got %0d required %0d", tag, i, rd_addr_q[rb+i], first8[i]);
            end
        end
        checks++;
        if (rd_addr_q[rb+NRD-1] !== 783 || max_addr > 783) begin
            errors++;
            $display("FAIL %s_last_raddr: last %0d max %0d required 783", tag,
                     rd_addr_q[rb+NRD-1], max_addr);
        end
        checks++;
        if (rd_cyc_q[rb+NRD-1] - f !== NRD - 1) begin
            errors++;
            $display("FAIL %s_rd_contiguous: span %0d required %0d", tag,
                     rd_cyc_q[rb+NRD-1] - f + 1, NRD);
        end
        checks++;
        if (done_cyc_q.size() <= r) begin
            errors++;
            $display("FAIL %s_done_seen: got %0d pulses required %0d", tag, done_cyc_q.size(), r + 1);
        end else begin
            checks++;
            if (done_cyc_q[r] - f + 1 !== 786) begin
                errors++;
                $display("FAIL %s_done_cycle: got %0d required 786", tag, done_cyc_q[r] - f + 1);
            end
            checks++;
            if (done_paddr_q[r] !== 195 || done_pv_q[r] !== 1'b1) begin
                errors++;
                $display("FAIL %s_done_align: p_addr %0d p_valid %0b required 195 1", tag,
                         done_paddr_q[r], done_pv_q[r]);
            end
        end
        checks++;
        if (hold_bad !== 0) begin
            errors++;
            $display("FAIL %s_hold: got %0d changes between pulses required 0", tag, hold_bad);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        checks++;
        if (busy !== 1'b0 || f2_rd_en !== 1'b0 || f2_raddr !== '0 || p_valid !== 1'b0 ||
            p_data !== '0 || p_addr !== '0 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s: busy %b rd_en %b raddr %0d pv %b pdata %h paddr %0d done %b required all 0",
                     tag, busy, f2_rd_en, f2_raddr, p_valid, p_data, p_addr, done);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset_asserted");
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check_outputs_zero("reset_idle");
    endtask

    task automatic test_ramp();
        clear_rec(); sig_mode = 1'b0;
        pulse_start();
        checks++;
        if (busy !== 1'b1 || f2_rd_en !== 1'b1 || f2_raddr !== '0) begin
            errors++;
            $display("FAIL ramp_first_cycle: busy %b rd_en %b raddr %0d required 1 1 0",
                     busy, f2_rd_en, f2_raddr);
        end
        wait_done("ramp");
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL ramp_busy_after_done: got %b required 0", busy);
        end
        repeat (3) @(negedge clk);
        check_run("ramp", 0, 1'b0);
    endtask

    task automatic test_signed();
        clear_rec(); sig_mode = 1'b1;
        pulse_start();
        wait_done("signed");
        repeat (4) @(negedge clk);
        check_run("signed", 0, 1'b1);
        sig_mode = 1'b0;
    endtask

    task automatic test_start_while_busy();
        clear_rec();
        pulse_start();
        repeat (98) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("busy_start");
        repeat (40) @(negedge clk);
        checks++;
        if (done_cyc_q.size() !== 1 || pv_data_q.size() !== NWIN) begin
            errors++;
            $display("FAIL busy_start_single_run: done %0d pv %0d required 1 %0d",
                     done_cyc_q.size(), pv_data_q.size(), NWIN);
        end
        check_run("busy_start", 0, 1'b0);
    endtask

    task automatic test_reset_midop();
        bit ok;
        clear_rec();
        pulse_start();
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            #1;
            if (rd_addr_q.size() >= 300) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL midreset_reach_read300: got %0d reads required 300", rd_addr_q.size());
        end
        rst = 1'b1;
        #1;
        check_outputs_zero("midreset_immediate");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        clear_rec();
        repeat (30) @(negedge clk);
        #1;
        checks++;
        if (pv_data_q.size() !== 0 || rd_addr_q.size() !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_quiet: pv %0d rd %0d busy %b required 0 0 0",
                     pv_data_q.size(), rd_addr_q.size(), busy);
        end
        clear_rec();
        pulse_start();
        wait_done("midreset_rerun");
        repeat (3) @(negedge clk);
        check_run("midreset_rerun", 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        clear_rec();
        pulse_start();
        wait_done("b2b_first");
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_busy_gap: got %b required 0", busy);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || f2_rd_en !== 1'b1 || f2_raddr !== '0) begin
            errors++;
            $display("FAIL b2b_restart: busy %b rd_en %b raddr %0d required 1 1 0",
                     busy, f2_rd_en, f2_raddr);
        end
        wait_done("b2b_second");
        repeat (3) @(negedge clk);
        checks++;
        if (done_cyc_q.size() !== 2) begin
            errors++;
            $display("FAIL b2b_done_count: got %0d required 2", done_cyc_q.size());
        end
        check_run("b2b_run1", 0, 1'b0);
        check_run("b2b_run2", 1, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        clear_rec();
        test_reset();
        test_ramp();
        test_signed();
        test_start_while_busy();
        test_reset_midop();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
